or_gate_checker: RTL
====================

OR_GATE_CHECKER -- requirements
Module: or_gate_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: number of settle cycles each input vector is driven before y_in is sampled (legal range 0..15).
REQ-002 The block SHALL have parameter PASSES, default 1: number of full sweeps over the four input vectors per run (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates a run in progress.
REQ-007 The block SHALL have port a_out, output, 1 bit: registered drive to the OR gate input a.
REQ-008 The block SHALL have port b_out, output, 1 bit: registered drive to the OR gate input b.
REQ-009 The block SHALL have port y_in, input, 1 bit: OR gate output under test, same clock domain, no synchronizer.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal completion of a run.
REQ-012 The block SHALL have port pass, output, 1 bit: high when the last completed run had zero mismatches.
REQ-013 The block SHALL have port err_count, output, 8 bits: mismatch count of the current or last run, saturating at 255.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE with start=1 and abort=0 SHALL go to DRIVE; it SHALL drive vector {a_out,b_out}=00, clear err_count, clear pass, set busy, and clear the pass counter.
REQ-016 In DRIVE a hold counter SHALL count HOLD_CYCLES cycles, then go to SAMPLE; HOLD_CYCLES=0 SHALL go straight to SAMPLE on the next edge.
REQ-017 In SAMPLE, on the clock edge, y_in SHALL be compared with (a_out | b_out); a mismatch SHALL increment err_count, saturating at 255.
REQ-018 Each vector SHALL be driven for exactly HOLD_CYCLES+1 cycles, with the sample taken at the edge that ends the last of those cycles.
REQ-019 Vector order SHALL be 00, 01, 10, 11 ({a_out,b_out}); after SAMPLE of a non-final vector the next vector SHALL be loaded and the FSM SHALL go to DRIVE.
REQ-020 After SAMPLE of vector 11, if passes completed < PASSES the block SHALL wrap to vector 00 and go to DRIVE, else go to DONE.
REQ-021 DONE SHALL last one cycle: done=1, busy=0, pass=(err_count==0) including the final sample, a_out=b_out=0; the next state SHALL be IDLE.
REQ-022 A full run SHALL take 4*PASSES*(HOLD_CYCLES+1) cycles from the first DRIVE cycle to the final sample, and done SHALL be asserted the cycle after the final sample.
REQ-023 start SHALL be ignored while busy=1 and during DONE.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL go to IDLE on the next edge: busy=0, a_out=b_out=0, no done pulse, pass=0, err_count retained, and an in-flight sample discarded.
REQ-025 In IDLE, abort=1 SHALL take priority over start, and the block SHALL remain in IDLE.
REQ-026 pass and err_count SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, and all counters 0.
REQ-028 Reset asserted mid-run SHALL abandon the run with no done pulse; after deassertion the block SHALL wait for a new start.
REQ-029 The first accepted start SHALL be the first rising edge with rst_n=1 and start=1.

Verification
REQ-030 Scenario: correct OR gate model, HOLD_CYCLES=2, PASSES=1, pulse start -> 12 busy cycles, vectors 00/01/10/11 each held 3 cycles, then done=1 for one cycle, pass=1, err_count=0.
REQ-031 Scenario: y_in stuck at 0, PASSES=1 -> done pulse, pass=0, err_count=3.
REQ-032 Scenario: y_in stuck at 1, PASSES=2, HOLD_CYCLES=0 -> 8 busy cycles, err_count=2, pass=0.
REQ-033 Scenario: abort asserted during the second vector's DRIVE -> next cycle busy=0, a_out=b_out=0, no done pulse, pass=0; start and abort asserted together in IDLE -> no run starts.
REQ-034 Scenario: rst_n pulsed low mid-run, asynchronously between clock edges -> outputs are 0 immediately; a new start afterwards gives a clean run with err_count starting from 0.
REQ-035 Scenario: y_in stuck at 0, PASSES=255, HOLD_CYCLES=0 -> err_count saturates at 255 and does not wrap; start pulses while busy have no effect.

Source files
------------

// File: rtl/or_gate_checker.sv
// or_gate_checker: sweeps the four input vectors of an external OR gate,
// holds each for HOLD_CYCLES+1 cycles and counts mismatches on y_in.
module or_gate_checker #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned PASSES      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // DRIVE covers the first HOLD_CYCLES cycles of a vector and SAMPLE its
    // final cycle; with HOLD_CYCLES=0 DRIVE is skipped so every vector still
    // occupies exactly HOLD_CYCLES+1 cycles.
    localparam state_t     VEC_ENTRY = (HOLD_CYCLES == 0) ? SAMPLE : DRIVE;
    localparam logic [3:0] HOLD_LAST = 4'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [8:0] PASS_NUM  = 9'(PASSES);

    state_t     state_q, state_d;
    logic [1:0] ab_q, ab_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_q, err_d;

    logic       mismatch;
    logic [7:0] err_inc;

    // Compare the gate output against the expected OR of the driven vector.
    always_comb begin
        mismatch = y_in != (ab_q[1] | ab_q[0]);
        err_inc  = (mismatch && (err_q != '1)) ? err_q + 8'd1 : err_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ab_d       = ab_q;
        hold_d     = hold_q;
        pass_cnt_d = pass_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d    = VEC_ENTRY;
                    ab_d       = 2'b00;
                    hold_d     = '0;
                    pass_cnt_d = '0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_d      = '0;
                end
            end

            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    ab_d    = 2'b00;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    ab_d    = 2'b00;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    err_d = err_inc;
                    if (ab_q != 2'b11) begin
                        ab_d    = ab_q + 2'd1;
                        state_d = VEC_ENTRY;
                    end else if (({1'b0, pass_cnt_q} + 9'd1) < PASS_NUM) begin
                        ab_d       = 2'b00;
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        state_d    = VEC_ENTRY;
                    end else begin
                        ab_d    = 2'b00;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ab_q       <= '0;
            hold_q     <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ab_q       <= ab_d;
            hold_q     <= hold_d;
            pass_cnt_q <= pass_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule
